// File: rtl/vga_fb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_fb_arbiter_if
//  Description : Bundle of every vga_fb_arbiter signal except clock and reset.
//                The slave modport is the arbiter's view. The master modport is
//                the surrounding system's view: the timing generator, the
//                write client, the clear requester and the frame-buffer RAM.
//                Signals:
//                  pos_x/pos_y    look-ahead pixel position (0x3FF = none)
//                  pix_data       expanded 24-bit colour
//                  wr_*           buffered write client (valid/ready)
//                  clr_*          clear engine request/colour/busy
//                  ram_*          single-port frame-buffer RAM
//  Revision    : 1.0 - initial release
// ============================================================================
interface vga_fb_arbiter_if;
    logic [9:0]  pos_x;
    logic [9:0]  pos_y;
    logic [23:0] pix_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  wr_x;
    logic [6:0]  wr_y;
    logic [7:0]  wr_color;
    logic        wr_drop;
    logic        clr_req;
    logic [7:0]  clr_color;
    logic        clr_busy;
    logic        ram_en;
    logic        ram_we;
    logic [14:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    modport slave (
        input  pos_x, pos_y, wr_valid, wr_x, wr_y, wr_color,
               clr_req, clr_color, ram_rdata,
        output pix_data, wr_ready, wr_drop, clr_busy,
               ram_en, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output pos_x, pos_y, wr_valid, wr_x, wr_y, wr_color,
               clr_req, clr_color, ram_rdata,
        input  pix_data, wr_ready, wr_drop, clr_busy,
               ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface
`default_nettype wire

// File: rtl/vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : vga_fb_arbiter
//  Description : Owner of the single frame-buffer RAM port (FB_W x FB_H cells
//                of RGB332, each cell covering 4x4 screen pixels). Display
//                reads are issued combinationally on cell-aligned look-ahead
//                positions and always win the port. The remaining cycles
//                serve the hardware clear engine first, then a small write
//                FIFO. The stored colour is expanded to 24 bits for the VGA
//                timing generator, one cycle after the request.
//                Ports:
//                  vga_clk  pixel clock
//                  sys_rst  asynchronous active-high reset
//                  bus      vga_fb_arbiter_if.slave (position, pixel, write
//                           client, clear and RAM signals)
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_fb_arbiter #(
    parameter int FB_W       = 160,
    parameter int FB_H       = 120,
    parameter int FIFO_DEPTH = 4
) (
    input  wire             vga_clk,
    input  wire             sys_rst,
    vga_fb_arbiter_if.slave bus
);

    localparam int          c_PTR_W     = $clog2(FIFO_DEPTH);
    localparam int          c_CNT_W     = c_PTR_W + 1;
    localparam logic [14:0] c_LAST_ADDR = 15'(FB_W * FB_H - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_t;

    function automatic logic [23:0] f_expand(input logic [7:0] c);
        return {c[7:5], c[7:5], c[7:6], c[4:2], c[4:2], c[4:3],
                c[1:0], c[1:0], c[1:0], c[1:0]};
    endfunction

    // ---------------------------------------------------------------- read slot
    logic        w_req_valid;
    logic        w_rd_slot;
    logic        w_free_slot;
    logic [14:0] w_rd_addr;

    assign w_req_valid = (bus.pos_x != 10'h3FF) && (bus.pos_y != 10'h3FF);
    assign w_rd_slot   = w_req_valid && (bus.pos_x[1:0] == 2'b00);
    assign w_free_slot = !w_rd_slot;
    assign w_rd_addr   = 15'(bus.pos_y[9:2]) * 15'(FB_W) + 15'(bus.pos_x[9:2]);

    // ---------------------------------------------------------------- write FIFO
    logic [14:0]        r_fifo_addr  [FIFO_DEPTH];
    logic [7:0]         r_fifo_color [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_wr_drop;
    logic               w_full;
    logic               w_empty;
    logic               w_accept;
    logic               w_in_range;
    logic               w_push;
    logic               w_pop;
    logic [14:0]        w_wr_addr;

    assign w_full     = (r_count == c_CNT_W'(FIFO_DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_accept   = bus.wr_valid && !w_full;
    assign w_in_range = (int'(bus.wr_x) < FB_W) && (int'(bus.wr_y) < FB_H);
    assign w_push     = w_accept && w_in_range;
    assign w_wr_addr  = 15'(bus.wr_y) * 15'(FB_W) + 15'(bus.wr_x);

    // Storage is not reset: a flush only needs the pointers and count cleared.
    always_ff @(posedge vga_clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr]  <= w_wr_addr;
            r_fifo_color[r_wr_ptr] <= bus.wr_color;
        end
    end

    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_wr_drop <= 1'b0;
        end else begin
            r_wr_drop <= w_accept && !w_in_range;
            if (w_push)
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            if (w_push && !w_pop)
                r_count <= r_count + c_CNT_W'(1);
            else if (w_pop && !w_push)
                r_count <= r_count - c_CNT_W'(1);
        end
    end

    // ---------------------------------------------------------------- clear FSM
    clr_state_t  r_state;
    clr_state_t  w_state_nxt;
    logic [14:0] r_clr_cnt;
    logic [14:0] w_clr_cnt_nxt;
    logic [7:0]  r_clr_color;
    logic [7:0]  w_clr_color_nxt;
    logic        w_clr_busy;

    assign w_clr_busy = (r_state == ST_CLEAR);

    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state     <= ST_IDLE;
            r_clr_cnt   <= '0;
            r_clr_color <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_clr_cnt   <= w_clr_cnt_nxt;
            r_clr_color <= w_clr_color_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_clr_cnt_nxt   = r_clr_cnt;
        w_clr_color_nxt = r_clr_color;
        case (r_state)
            ST_IDLE: begin
                if (bus.clr_req) begin
                    w_state_nxt     = ST_CLEAR;
                    w_clr_cnt_nxt   = '0;
                    w_clr_color_nxt = bus.clr_color;
                end
            end
            ST_CLEAR: begin
                // Only free slots advance the sweep; reads stall it.
                if (w_free_slot) begin
                    if (r_clr_cnt == c_LAST_ADDR) begin
                        w_state_nxt   = ST_IDLE;
                        w_clr_cnt_nxt = '0;
                    end else begin
                        w_clr_cnt_nxt = r_clr_cnt + 15'd1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- RAM port
    // FIFO drains only when the clear engine is idle, so queued writes land
    // on top of a freshly cleared image.
    assign w_pop = w_free_slot && !w_clr_busy && !w_empty;

    logic        w_ram_en;
    logic        w_ram_we;
    logic [14:0] w_ram_addr;
    logic [7:0]  w_ram_wdata;

    always_comb begin
        w_ram_en    = 1'b0;
        w_ram_we    = 1'b0;
        w_ram_addr  = '0;
        w_ram_wdata = '0;
        if (w_rd_slot) begin
            w_ram_en   = 1'b1;
            w_ram_addr = w_rd_addr;
        end else if (w_clr_busy) begin
            w_ram_en    = 1'b1;
            w_ram_we    = 1'b1;
            w_ram_addr  = r_clr_cnt;
            w_ram_wdata = r_clr_color;
        end else if (!w_empty) begin
            w_ram_en    = 1'b1;
            w_ram_we    = 1'b1;
            w_ram_addr  = r_fifo_addr[r_rd_ptr];
            w_ram_wdata = r_fifo_color[r_rd_ptr];
        end
    end

    // ---------------------------------------------------------------- pixel path
    logic       r_rd_d;
    logic       r_act_d;
    logic [7:0] r_hold_q;
    logic [23:0] w_pix;

    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_rd_d   <= 1'b0;
            r_act_d  <= 1'b0;
            r_hold_q <= '0;
        end else begin
            r_rd_d  <= w_rd_slot;
            r_act_d <= w_req_valid;
            if (r_rd_d)
                r_hold_q <= bus.ram_rdata;
        end
    end

    // Fresh RAM data on the cycle after a read; the held copy covers the
    // other three pixels of the cell.
    always_comb begin
        w_pix = '0;
        if (r_act_d)
            w_pix = r_rd_d ? f_expand(bus.ram_rdata) : f_expand(r_hold_q);
    end

    assign bus.pix_data  = w_pix;
    assign bus.wr_ready  = !w_full;
    assign bus.wr_drop   = r_wr_drop;
    assign bus.clr_busy  = w_clr_busy;
    assign bus.ram_en    = w_ram_en;
    assign bus.ram_we    = w_ram_we;
    assign bus.ram_addr  = w_ram_addr;
    assign bus.ram_wdata = w_ram_wdata;

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_fb_arbiter
//  Description : Self-checking bench for vga_fb_arbiter. Holds a behavioural
//                frame-buffer RAM and a cell-level reference model (image
//                array, write queue, clear sweep index) and compares every
//                cycle's RAM access, pixel and status outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_fb_arbiter;

    localparam int FB_W  = 160;
    localparam int FB_H  = 120;
    localparam int DEPTH = 4;
    localparam int CELLS = FB_W * FB_H;

    logic vga_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic ram_init = 1'b1;

    vga_fb_arbiter_if bus ();

    vga_fb_arbiter #(
        .FB_W       (FB_W),
        .FB_H       (FB_H),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .vga_clk (vga_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    always #5 vga_clk = ~vga_clk;

    function automatic logic [7:0] f_init(input int i);
        return 8'((i * 37 + 11) & 255);
    endfunction

    // External RAM: single port, registered read.
    logic [7:0] ram [CELLS];
    always @(posedge vga_clk) begin
        if (ram_init) begin
            for (int i = 0; i < CELLS; i++) ram[i] <= f_init(i);
            bus.ram_rdata <= 8'h00;
        end else if (bus.ram_en && int'(bus.ram_addr) < CELLS) begin
            if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
            else            bus.ram_rdata     <= ram[bus.ram_addr];
        end
    end

    // ---------------------------------------------------------------- model
    logic [7:0]  ref_mem [CELLS];
    logic [22:0] ref_q[$];
    bit          clr_on;
    int          clr_idx;
    logic [7:0]  clr_col;
    logic [23:0] exp_pix;
    bit          exp_drop;
    logic [7:0]  last_rd;
    int          n_acc;
    int          checks = 0;
    int          errors = 0;
    int          sx = 0, sy = 0, sblank = 0;

    function automatic logic [23:0] ref_expand(input logic [7:0] c);
        int r, g, b;
        r = int'(c[7:5]);
        g = int'(c[4:2]);
        b = int'(c[1:0]);
        return {8'(r * 36 + r / 2), 8'(g * 36 + g / 2), 8'(b * 85)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        ref_q.delete();
        clr_on   = 1'b0;
        clr_idx  = 0;
        exp_pix  = '0;
        exp_drop = 1'b0;
        last_rd  = '0;
    endtask

    // Scanning position source: 640 active pixels on a random row, then a
    // short blanking gap that also exercises half-invalid positions.
    task automatic drive_pos();
        if (sblank > 0) begin
            case ($urandom_range(0, 2))
                0: begin bus.pos_x = 10'h3FF; bus.pos_y = 10'h3FF; end
                1: begin bus.pos_x = 10'h3FF; bus.pos_y = 10'(sy); end
                default: begin bus.pos_x = 10'($urandom_range(0, 639)); bus.pos_y = 10'h3FF; end
            endcase
            sblank--;
            if (sblank == 0) begin
                sx = 0;
                sy = $urandom_range(0, 479);
            end
        end else begin
            bus.pos_x = 10'(sx);
            bus.pos_y = 10'(sy);
            sx++;
            if (sx == 640) sblank = 16;
        end
    endtask

    // One clock: check this cycle's outputs at the falling edge, advance the
    // model, then return just after the rising edge for the next drive.
    task automatic tick();
        bit valid, rd;
        int a_rd, e_addr;
        bit e_en, e_we, ready, was_clr;
        logic [7:0] e_dat;
        logic [24:0] exp_acc, got_acc;

        @(negedge vga_clk);
        valid = (bus.pos_x != 10'h3FF) && (bus.pos_y != 10'h3FF);
        rd    = valid && (bus.pos_x % 4 == 0);
        a_rd  = int'(bus.pos_y / 4) * FB_W + int'(bus.pos_x / 4);
        e_en = 0; e_we = 0; e_addr = 0; e_dat = 0;
        if (rd) begin
            e_en = 1; e_addr = a_rd;
        end else if (clr_on) begin
            e_en = 1; e_we = 1; e_addr = clr_idx; e_dat = clr_col;
        end else if (ref_q.size() > 0) begin
            e_en = 1; e_we = 1; e_addr = int'(ref_q[0][22:8]); e_dat = ref_q[0][7:0];
        end
        exp_acc = {e_en, e_we, 15'(e_addr), e_dat};
        got_acc = {bus.ram_en, bus.ram_we, bus.ram_en ? bus.ram_addr : 15'd0,
                   bus.ram_we ? bus.ram_wdata : 8'd0};
        chk("ram_access", 32'(got_acc), 32'(exp_acc));
        chk("pix_data", 32'(bus.pix_data), 32'(exp_pix));
        chk("wr_drop", 32'(bus.wr_drop), 32'(exp_drop));
        chk("wr_ready", 32'(bus.wr_ready), 32'(ref_q.size() < DEPTH));
        chk("clr_busy", 32'(bus.clr_busy), 32'(clr_on));

        ready   = ref_q.size() < DEPTH;
        was_clr = clr_on;
        if (rd) last_rd = ref_mem[a_rd];
        exp_pix = valid ? ref_expand(last_rd) : 24'h0;
        if (e_we) begin
            ref_mem[e_addr] = e_dat;
            if (clr_on) begin
                if (clr_idx == CELLS - 1) clr_on = 1'b0;
                else                      clr_idx++;
            end else begin
                void'(ref_q.pop_front());
            end
        end
        exp_drop = 1'b0;
        if (bus.wr_valid && ready) begin
            n_acc++;
            if (int'(bus.wr_x) < FB_W && int'(bus.wr_y) < FB_H)
                ref_q.push_back({15'(int'(bus.wr_y) * FB_W + int'(bus.wr_x)), bus.wr_color});
            else
                exp_drop = 1'b1;
        end
        if (bus.clr_req && !was_clr) begin
            clr_on  = 1'b1;
            clr_idx = 0;
            clr_col = bus.clr_color;
        end
        @(posedge vga_clk);
        #1;
    endtask

    task automatic rst_cycles(input int n);
        sys_rst      = 1'b1;
        bus.wr_valid = 1'b0;
        bus.clr_req  = 1'b0;
        repeat (n) begin
            drive_pos();
            @(negedge vga_clk);
            chk("rst_pix", 32'(bus.pix_data), 32'h0);
            chk("rst_ready", 32'(bus.wr_ready), 32'h1);
            chk("rst_drop", 32'(bus.wr_drop), 32'h0);
            chk("rst_busy", 32'(bus.clr_busy), 32'h0);
            chk("rst_we", 32'(bus.ram_we), 32'h0);
            @(posedge vga_clk);
            #1;
        end
        model_reset();
        ram_init = 1'b0;
        sys_rst  = 1'b0;
    endtask

    task automatic set_wr(input bit v, input int x, input int y, input logic [7:0] c);
        bus.wr_valid = v;
        bus.wr_x     = 8'(x);
        bus.wr_y     = 7'(y);
        bus.wr_color = c;
    endtask

    task automatic set_pos(input int x, input int y);
        bus.pos_x = 10'(x);
        bus.pos_y = 10'(y);
    endtask

    int mism, base, guard;

    initial begin
        for (int i = 0; i < CELLS; i++) ref_mem[i] = f_init(i);
        model_reset();
        n_acc = 0;
        set_pos(1023, 1023);
        set_wr(0, 0, 0, 8'h00);
        bus.clr_req   = 1'b0;
        bus.clr_color = 8'h00;
        @(posedge vga_clk);
        #1;
        rst_cycles(3);

        // Cell 0 = 0xE0, then read one full cell: pure red on all four pixels.
        set_pos(1023, 1023);
        set_wr(1, 0, 0, 8'hE0);
        tick();
        set_wr(0, 0, 0, 8'h00);
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            set_pos(i, 0);
            tick();
            chk("red_pixel", 32'(bus.pix_data), 32'hFF0000);
        end
        set_pos(1023, 1023);
        tick();
        chk("blank_pixel", 32'(bus.pix_data), 32'h0);

        // Last cell written while active video is scanning row 0.
        sx = 0; sy = 0; sblank = 0;
        set_wr(1, 159, 119, 8'h1C);
        drive_pos();
        tick();
        set_wr(0, 0, 0, 8'h00);
        repeat (8) begin drive_pos(); tick(); end
        set_pos(636, 476);
        tick();
        chk("green_pixel", 32'(bus.pix_data), 32'h00FF00);

        // Out-of-range write: consumed, dropped, no RAM write.
        set_pos(1023, 1023);
        set_wr(1, 160, 5, 8'hFF);
        tick();
        set_wr(0, 0, 0, 8'h00);
        chk("drop_pulse", 32'(bus.wr_drop), 32'h1);
        tick();
        chk("drop_once", 32'(bus.wr_drop), 32'h0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            drive_pos();
            set_wr($urandom_range(0, 2) == 0, $urandom_range(0, 170),
                   $urandom_range(0, 127), 8'($urandom_range(0, 255)));
            tick();
        end
        set_wr(0, 0, 0, 8'h00);
        guard = 0;
        while (ref_q.size() > 0 && guard < 200) begin drive_pos(); tick(); guard++; end
        chk("fifo_drained", 32'(ref_q.size()), 32'h0);

        // Clear with FIFO backpressure.
        drive_pos();
        bus.clr_req   = 1'b1;
        bus.clr_color = 8'h03;
        tick();
        bus.clr_req = 1'b0;
        base = n_acc;
        for (int i = 0; i < 6; i++) begin
            drive_pos();
            set_wr(1, i, 100 + i, 8'(8'h40 + i));
            tick();
        end
        set_wr(0, 0, 0, 8'h00);
        chk("accepted_4", 32'(n_acc - base), 32'd4);
        guard = 0;
        while ((clr_on || ref_q.size() > 0) && guard < 40000) begin
            drive_pos(); tick(); guard++;
        end
        chk("clear_done", 32'(clr_on || ref_q.size() > 0), 32'h0);
        drive_pos();
        tick();
        chk("cell0_clr", 32'(ram[0]), 32'h03);
        chk("cell_last_clr", 32'(ram[CELLS - 1]), 32'h03);
        chk("beat0_on_top", 32'(ram[100 * FB_W]), 32'h40);
        chk("beat3_on_top", 32'(ram[103 * FB_W + 3]), 32'h43);
        chk("beat4_lost", 32'(ram[104 * FB_W + 4]), 32'h03);

        // Reset in the middle of a clear sweep.
        drive_pos();
        bus.clr_req   = 1'b1;
        bus.clr_color = 8'h5A;
        tick();
        bus.clr_req = 1'b0;
        guard = 0;
        while (clr_idx < 500 && guard < 2000) begin drive_pos(); tick(); guard++; end
        chk("clear_reached_500", 32'(clr_idx), 32'd500);
        drive_pos();
        set_wr(1, 7, 7, 8'h99);
        tick();
        rst_cycles(3);
        for (int n = 0; n < 60; n++) begin
            drive_pos();
            tick();
            chk("no_write_after_rst", 32'(bus.ram_we), 32'h0);
        end

        mism = 0;
        for (int i = 0; i < CELLS; i++) if (ram[i] !== ref_mem[i]) mism++;
        chk("ram_image", 32'(mism), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
